boot_loader_stream: RTL and testbench



---
 rtl/boot_pkg.sv | 20 ++
 rtl/boot_word_packer.sv | 30 +++
 rtl/boot_loader_stream.sv | 135 +++++++++++++
 tb/tb_boot_loader_stream.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared state encoding and frame constants for the streaming boot loader.
package boot_pkg;

  localparam logic [7:0] BOOT_MAGIC = 8'hA5;
  localparam logic [7:0] TGT_ROM    = 8'h00;
  localparam logic [7:0] TGT_RAM    = 8'h01;
  localparam int         CHK_W      = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TARGET,
    ST_CNT_LO,
    ST_CNT_HI,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } boot_state_t;

endpackage

// File: rtl/boot_word_packer.sv
// Collects four payload bytes, little-endian, into one 32-bit word.
module boot_word_packer (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [23:0] shreg_q;
  logic [1:0]  lane_q;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst_i || clr_i) begin
      shreg_q <= '0;
      lane_q  <= '0;
    end else if (byte_valid_i) begin
      shreg_q <= {byte_i, shreg_q[23:8]};
      lane_q  <= lane_q + 2'd1;
    end
  end

  // The lane-3 byte bypasses the shift register so the word is ready on its own acceptance edge.
  assign word_valid_o = byte_valid_i && (lane_q == 2'd3);
  assign word_o       = {byte_i, shreg_q};

endmodule

// File: rtl/boot_loader_stream.sv
// Frame parser that writes a checksummed image into ROM/RAM and then releases the core.
module boot_loader_stream
  import boot_pkg::*;
#(
  parameter int         ADDR_W = 10,
  parameter logic [7:0] MAGIC  = BOOT_MAGIC
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              mem_we,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rstn,
  output logic              done,
  output logic              err
);

  localparam int MAX_WORDS = 1 << ADDR_W;

  boot_state_t       state_q, state_d;
  logic              s_ready_q, s_ready_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              core_rstn_q, core_rstn_d;
  logic              mem_we_q, mem_sel_q;
  logic [ADDR_W-1:0] mem_addr_q, widx_q, last_idx_q;
  logic [31:0]       mem_wdata_q;
  logic [7:0]        cnt_lo_q;
  logic [CHK_W-1:0]  chk_q;
  logic [15:0]       count_w;
  logic              accept, word_valid;
  logic [31:0]       word;

  assign accept  = s_valid && s_ready_q;
  assign count_w = {s_data, cnt_lo_q};

  boot_word_packer u_packer (
    .clk          (clk),
    .rst_i        (Rst),
    .clr_i        (state_q == ST_CNT_HI),
    .byte_valid_i (accept && (state_q == ST_DATA)),
    .byte_i       (s_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q     <= ST_IDLE;
      s_ready_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      core_rstn_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_ready_q   <= s_ready_d;
      done_q      <= done_d;
      err_q       <= err_d;
      core_rstn_q <= core_rstn_d;
    end
  end

  // NOTE: state_d defaults to state_q before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (accept && s_data == MAGIC) state_d = ST_TARGET;
      ST_TARGET: if (accept) state_d = (s_data == TGT_ROM || s_data == TGT_RAM) ? ST_CNT_LO : ST_ERROR;
      ST_CNT_LO: if (accept) state_d = ST_CNT_HI;
      ST_CNT_HI: if (accept) begin
        if (int'(count_w) > MAX_WORDS) state_d = ST_ERROR;
        else if (count_w == 16'd0)     state_d = ST_CHECK;
        else                           state_d = ST_DATA;
      end
      ST_DATA:   if (word_valid && widx_q == last_idx_q) state_d = ST_CHECK;
      ST_CHECK:  if (accept) state_d = (s_data == chk_q) ? ST_DONE : ST_ERROR;
      default:   state_d = state_q;
    endcase
  end

  // Outputs are registered from the next state so they change on the entry edge itself.
  always_comb begin
    s_ready_d   = !(state_d inside {ST_DONE, ST_ERROR});
    done_d      = (state_d == ST_DONE);
    err_d       = (state_d == ST_ERROR);
    core_rstn_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      mem_we_q    <= 1'b0;
      mem_sel_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      widx_q      <= '0;
      last_idx_q  <= '0;
      cnt_lo_q    <= '0;
      chk_q       <= '0;
    end else begin
      mem_we_q <= word_valid;
      if (word_valid) begin
        mem_addr_q  <= widx_q;
        mem_wdata_q <= word;
        widx_q      <= widx_q + ADDR_W'(1);
      end
      if (accept) begin
        unique case (state_q)
          ST_TARGET: if (s_data == TGT_ROM || s_data == TGT_RAM) mem_sel_q <= s_data[0];
          ST_CNT_LO: cnt_lo_q <= s_data;
          ST_CNT_HI: begin
            last_idx_q <= ADDR_W'(count_w - 16'd1);
            widx_q     <= '0;
            chk_q      <= '0;
          end
          ST_DATA:   chk_q <= chk_q + s_data;
          default:   ;
        endcase
      end
    end
  end

  assign s_ready   = s_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_sel   = mem_sel_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign core_rstn = core_rstn_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_boot_loader_stream.sv
// Randomized scoreboard bench: a frame-level parser model predicts writes and final status.
module tb_boot_loader_stream;

  localparam int ADDR_W  = 10;
  localparam int ST_PEND = 0;
  localparam int ST_DONE = 1;
  localparam int ST_ERR  = 2;

  typedef struct {
    logic              sel;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic              clk = 1'b0;
  logic              Rst = 1'b1;
  logic [7:0]        s_data = 8'h00;
  logic              s_valid = 1'b0;
  logic              s_ready, mem_we, mem_sel, core_rstn, done, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  boot_loader_stream #(.ADDR_W(ADDR_W), .MAGIC(8'hA5)) dut (
    .clk       (clk),
    .Rst       (Rst),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .mem_we    (mem_we),
    .mem_sel   (mem_sel),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .core_rstn (core_rstn),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  wr_t        exp_q[$];
  int         we_cyc[$];
  logic [7:0] stim[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: every write strobe must match the oldest predicted write.
  always @(negedge clk) begin
    wr_t e;
    if (mem_we === 1'b1) begin
      we_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %h data %h, expected no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_sel",  32'(mem_sel),  32'(e.sel));
        check("wr_addr", 32'(mem_addr), 32'(e.addr));
        check("wr_data", mem_wdata,     e.data);
      end
    end
  end

  // Frame-level reference: walks stim, queues the writes it implies, returns bytes consumed and outcome.
  function automatic void model(output int consumed, output int status);
    int         pos = 0;
    int         len = stim.size();
    int         n;
    logic [7:0] tgt;
    logic [7:0] sum = 8'h00;
    consumed = len;
    status   = ST_PEND;
    while (pos < len && stim[pos] != 8'hA5) pos++;
    pos++;
    if (pos >= len) return;
    tgt = stim[pos];
    pos++;
    if (tgt > 8'h01) begin consumed = pos; status = ST_ERR; return; end
    if (pos + 2 > len) return;
    n = int'({stim[pos+1], stim[pos]});
    pos += 2;
    if (n > (1 << ADDR_W)) begin consumed = pos; status = ST_ERR; return; end
    for (int w = 0; w < n; w++) begin
      if (pos + 4 > len) return;
      exp_q.push_back(wr_t'{tgt[0], ADDR_W'(w), {stim[pos+3], stim[pos+2], stim[pos+1], stim[pos]}});
      sum = sum + stim[pos] + stim[pos+1] + stim[pos+2] + stim[pos+3];
      pos += 4;
    end
    if (pos >= len) return;
    status   = (stim[pos] == sum) ? ST_DONE : ST_ERR;
    consumed = pos + 1;
  endfunction

  function automatic void build(input logic [7:0] tgt, input int n, input bit bad, input int garbage);
    logic [7:0] b;
    logic [7:0] sum = 8'h00;
    stim.delete();
    for (int i = 0; i < garbage; i++) begin
      b = 8'($urandom_range(0, 255));
      stim.push_back((b == 8'hA5) ? 8'h5A : b);
    end
    stim.push_back(8'hA5);
    stim.push_back(tgt);
    stim.push_back(n[7:0]);
    stim.push_back(n[15:8]);
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom_range(0, 255));
      stim.push_back(b);
      sum = sum + b;
    end
    stim.push_back(bad ? (sum ^ 8'h01) : sum);
  endfunction

  task automatic do_reset();
    Rst     = 1'b1;
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 Rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int budget = 0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    s_valid = 1'b1;
    s_data  = b;
    forever begin
      @(negedge clk);
      if (s_ready === 1'b1) break;
      budget++;
      if (budget > 50) begin
        n_tests++;
        n_fail++;
        $display("FAIL handshake_timeout: got s_ready=%b for 50 cycles, expected 1", s_ready);
        @(posedge clk);
        #1 s_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  task automatic run_frame(input string name, input int gap_max, input bit do_rst);
    int consumed, status;
    if (do_rst) do_reset();
    model(consumed, status);
    for (int i = 0; i < consumed; i++) send_byte(stim[i], $urandom_range(0, gap_max));
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({name, "/pending_writes"}, 32'(exp_q.size()), 0);
    check({name, "/done"},      32'(done),      32'(status == ST_DONE));
    check({name, "/err"},       32'(err),       32'(status == ST_ERR));
    check({name, "/core_rstn"}, 32'(core_rstn), 32'(status == ST_DONE));
    check({name, "/s_ready"},   32'(s_ready),   32'(status == ST_PEND));
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "/s_ready"},   32'(s_ready),   0);
    check({name, "/mem_we"},    32'(mem_we),    0);
    check({name, "/mem_sel"},   32'(mem_sel),   0);
    check({name, "/mem_addr"},  32'(mem_addr),  0);
    check({name, "/mem_wdata"}, mem_wdata,      0);
    check({name, "/core_rstn"}, 32'(core_rstn), 0);
    check({name, "/done"},      32'(done),      0);
    check({name, "/err"},       32'(err),       0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;

    stim = {8'hA5, 8'h00, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
    run_frame("rom2", 2, 1'b1);

    stim = {8'h11, 8'h22, 8'hA5, 8'h01, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h38};
    run_frame("garbage_ram1", 2, 1'b1);

    stim = {8'hA5, 8'h00, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hB7};
    run_frame("bad_chk", 1, 1'b1);

    stim = {8'hA5, 8'h02, 8'h01, 8'h00};
    run_frame("bad_target", 1, 1'b1);

    stim = {8'hA5, 8'h00, 8'h01, 8'h04};
    run_frame("oversize", 1, 1'b1);

    stim = {8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame("zero_len", 1, 1'b1);

    build(8'h01, 4, 1'b0, 0);
    we_cyc.delete();
    run_frame("throughput", 0, 1'b1);
    check("throughput/n_writes", 32'(we_cyc.size()), 4);
    for (int i = 1; i < we_cyc.size(); i++)
      check("throughput/spacing", 32'(we_cyc[i] - we_cyc[i-1]), 4);

    // Reset after two payload bytes: nothing written, outputs back to reset values.
    do_reset();
    we_cyc.delete();
    stim = {8'hA5, 8'h00, 8'h01, 8'h00, 8'h12, 8'h34};
    run_frame("partial", 1, 1'b0);
    Rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("mid_word_reset");
    #1 Rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset on the same edge that accepts lane 3: the word must never be written.
    stim = {8'hA5, 8'h01, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33};
    run_frame("pre_collide", 1, 1'b0);
    s_valid = 1'b1;
    s_data  = 8'h44;
    Rst     = 1'b1;
    @(posedge clk);
    #1 s_valid = 1'b0;
    @(negedge clk);
    check("collide/mem_we", 32'(mem_we), 0);
    check("collide/no_writes_seen", 32'(we_cyc.size()), 0);
    #1 Rst = 1'b0;
    @(posedge clk);
    #1;

    build(8'h00, 3, 1'b0, 2);
    run_frame("after_reset", 1, 1'b0);

    for (int t = 0; t < 10; t++) begin
      build(8'($urandom_range(0, 1)), $urandom_range(1, 6), ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
      run_frame($sformatf("rand%0d", t), 2, 1'b1);
    end

    build(8'h01, 1 << ADDR_W, 1'b0, 0);
    run_frame("max_len", 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
